// File: rtl/dual_issue_scoreboard_if.sv
// Issue/writeback bundle between the dual-issue front end and dual_issue_scoreboard.
// A slot issues on a rising edge where issue_validK && issue_readyK; ready never depends on its own slot's valid.
interface dual_issue_scoreboard_if #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5
);
   logic                issue_valid1;
   logic [ADDR_W-1:0]   Rs1_addr1;
   logic [ADDR_W-1:0]   Rs2_addr1;
   logic [ADDR_W-1:0]   Rd_addr1;
   logic                Rd_wen1;
   logic                issue_valid2;
   logic [ADDR_W-1:0]   Rs1_addr2;
   logic [ADDR_W-1:0]   Rs2_addr2;
   logic [ADDR_W-1:0]   Rd_addr2;
   logic                Rd_wen2;
   logic                issue_ready1;
   logic                issue_ready2;
   logic                Wen1;
   logic [ADDR_W-1:0]   Rd_addr1_wb;
   logic                Wen2;
   logic [ADDR_W-1:0]   Rd_addr2_wb;
   logic [NUM_REGS-1:0] busy_vec;
   logic                sb_err;
   logic [31:0]         stall_cycles;

   modport master (
      output issue_valid1, Rs1_addr1, Rs2_addr1, Rd_addr1, Rd_wen1,
      output issue_valid2, Rs1_addr2, Rs2_addr2, Rd_addr2, Rd_wen2,
      output Wen1, Rd_addr1_wb, Wen2, Rd_addr2_wb,
      input  issue_ready1, issue_ready2, busy_vec, sb_err, stall_cycles
   );

   modport slave (
      input  issue_valid1, Rs1_addr1, Rs2_addr1, Rd_addr1, Rd_wen1,
      input  issue_valid2, Rs1_addr2, Rs2_addr2, Rd_addr2, Rd_wen2,
      input  Wen1, Rd_addr1_wb, Wen2, Rd_addr2_wb,
      output issue_ready1, issue_ready2, busy_vec, sb_err, stall_cycles
   );
endinterface

// File: rtl/dual_issue_scoreboard.sv
// Per-register pending-write counters gating a 2-wide in-order issue stage.
// Optional stall performance counter enabled by defining SB_STALL_CNT_EN.
module dual_issue_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int CNT_W    = 2
) (
   input logic               clk,
   input logic               rst,
   dual_issue_scoreboard_if.slave sb
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]    cnt_q [NUM_REGS];
   logic [CNT_W-1:0]    cnt_d [NUM_REGS];
   logic                sb_err_q, sb_err_d;
   logic [NUM_REGS-1:0] busy;

   logic       src1_busy, dst1_full, ready1, fire1;
   logic       src2_busy, raw_pair, same_rd_inc, dst2_full, ready2, fire2;
   logic [CNT_W:0] dst2_sum;
   logic [CNT_W:0] up_w, dn_w;

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         busy[r] = (cnt_q[r] != '0);
      end
   end

   assign src1_busy = busy[sb.Rs1_addr1] | busy[sb.Rs2_addr1];
   assign dst1_full = sb.Rd_wen1 & (sb.Rd_addr1 != '0) & (cnt_q[sb.Rd_addr1] == CNT_MAX);
   assign ready1    = ~src1_busy & ~dst1_full;
   assign fire1     = sb.issue_valid1 & ready1 & sb.Rd_wen1 & (sb.Rd_addr1 != '0);

   // Slot 2 must also see slot 1's destination as pending, since both read the file this cycle.
   assign src2_busy   = busy[sb.Rs1_addr2] | busy[sb.Rs2_addr2];
   assign raw_pair    = sb.issue_valid1 & sb.Rd_wen1 & (sb.Rd_addr1 != '0) &
                        ((sb.Rs1_addr2 == sb.Rd_addr1) | (sb.Rs2_addr2 == sb.Rd_addr1));
   assign same_rd_inc = fire1 & (sb.Rd_addr1 == sb.Rd_addr2);
   assign dst2_sum    = {1'b0, cnt_q[sb.Rd_addr2]} + {{CNT_W{1'b0}}, same_rd_inc};
   assign dst2_full   = sb.Rd_wen2 & (sb.Rd_addr2 != '0) & (dst2_sum >= {1'b0, CNT_MAX});
   assign ready2      = (ready1 | ~sb.issue_valid1) & ~src2_busy & ~raw_pair & ~dst2_full;
   assign fire2       = sb.issue_valid2 & ready2 & sb.Rd_wen2 & (sb.Rd_addr2 != '0);

   always_comb begin
      sb_err_d = sb_err_q;
      up_w     = '0;
      dn_w     = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (r != 0) begin
            up_w = {1'b0, cnt_q[r]}
                 + (CNT_W+1)'(fire1 && (sb.Rd_addr1 == ADDR_W'(r)))
                 + (CNT_W+1)'(fire2 && (sb.Rd_addr2 == ADDR_W'(r)));
            dn_w = (CNT_W+1)'(sb.Wen1 && (sb.Rd_addr1_wb == ADDR_W'(r)))
                 + (CNT_W+1)'(sb.Wen2 && (sb.Rd_addr2_wb == ADDR_W'(r)));
            // A writeback with nothing pending is a protocol error; hold at zero.
            if (dn_w > up_w) begin
               cnt_d[r] = '0;
               sb_err_d = 1'b1;
            end else begin
               cnt_d[r] = CNT_W'(up_w - dn_w);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
         sb_err_q <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
         sb_err_q <= sb_err_d;
      end
   end

   assign sb.issue_ready1 = ready1;
   assign sb.issue_ready2 = ready2;
   assign sb.busy_vec     = busy;
   assign sb.sb_err       = sb_err_q;

`ifdef SB_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;
   logic        stall1, stall_any;

   // A cycle counts once even when both slots are held back.
   assign stall1    = sb.issue_valid1 & ~ready1;
   assign stall_any = stall1 | (sb.issue_valid2 & ~ready2 & ~stall1);
   assign stall_d   = stall_q + {31'd0, stall_any};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end

   assign sb.stall_cycles = stall_q;
`else
   assign sb.stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Self-checking bench for dual_issue_scoreboard against a counter-array reference model.
module tb_dual_issue_scoreboard;
   localparam int NREG = 32;
   localparam int MAX  = 3;

   logic clk = 1'b0;
   logic clk_en = 1'b1;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   int          mcnt [NREG];
   bit          merr;
   int unsigned mstall;

   dual_issue_scoreboard_if #(.NUM_REGS(NREG), .ADDR_W(5)) bus ();

   dual_issue_scoreboard #(.NUM_REGS(NREG), .ADDR_W(5), .CNT_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (bus)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int r = 0; r < NREG; r++) mcnt[r] = 0;
      merr   = 1'b0;
      mstall = 0;
   endtask

   function automatic bit m_busy(int a);
      return (a != 0) && (mcnt[a] != 0);
   endfunction

   function automatic logic [NREG-1:0] m_busy_vec();
      logic [NREG-1:0] v;
      v = '0;
      for (int r = 1; r < NREG; r++) v[r] = (mcnt[r] != 0);
      return v;
   endfunction

   function automatic bit m_ready1();
      if (m_busy(int'(bus.Rs1_addr1)) || m_busy(int'(bus.Rs2_addr1))) return 1'b0;
      if (bus.Rd_wen1 && bus.Rd_addr1 != 0 && mcnt[bus.Rd_addr1] >= MAX) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_ready2();
      bit r1, f1;
      int add;
      r1  = m_ready1();
      f1  = bus.issue_valid1 && r1 && bus.Rd_wen1 && bus.Rd_addr1 != 0;
      add = (f1 && bus.Rd_addr1 == bus.Rd_addr2) ? 1 : 0;
      if (bus.issue_valid1 && !r1) return 1'b0;
      if (m_busy(int'(bus.Rs1_addr2)) || m_busy(int'(bus.Rs2_addr2))) return 1'b0;
      if (bus.issue_valid1 && bus.Rd_wen1 && bus.Rd_addr1 != 0 &&
          (bus.Rs1_addr2 == bus.Rd_addr1 || bus.Rs2_addr2 == bus.Rd_addr1)) return 1'b0;
      if (bus.Rd_wen2 && bus.Rd_addr2 != 0 && mcnt[bus.Rd_addr2] + add >= MAX) return 1'b0;
      return 1'b1;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      bus.issue_valid1 = 0; bus.Rs1_addr1 = 0; bus.Rs2_addr1 = 0; bus.Rd_addr1 = 0; bus.Rd_wen1 = 0;
      bus.issue_valid2 = 0; bus.Rs1_addr2 = 0; bus.Rs2_addr2 = 0; bus.Rd_addr2 = 0; bus.Rd_wen2 = 0;
      bus.Wen1 = 0; bus.Rd_addr1_wb = 0; bus.Wen2 = 0; bus.Rd_addr2_wb = 0;
   endtask

   task automatic set_slot1(bit v, int rs1, int rs2, int rd, bit wen);
      bus.issue_valid1 = v; bus.Rs1_addr1 = 5'(rs1); bus.Rs2_addr1 = 5'(rs2);
      bus.Rd_addr1 = 5'(rd); bus.Rd_wen1 = wen;
   endtask

   task automatic set_slot2(bit v, int rs1, int rs2, int rd, bit wen);
      bus.issue_valid2 = v; bus.Rs1_addr2 = 5'(rs1); bus.Rs2_addr2 = 5'(rs2);
      bus.Rd_addr2 = 5'(rd); bus.Rd_wen2 = wen;
   endtask

   task automatic set_wb(bit w1, int a1, bit w2, int a2);
      bus.Wen1 = w1; bus.Rd_addr1_wb = 5'(a1); bus.Wen2 = w2; bus.Rd_addr2_wb = 5'(a2);
   endtask

   // Advance one clock with the current inputs and update the model.
   task automatic cycle();
      bit r1, r2, f1, f2, st;
      int n;
      r1 = m_ready1();
      r2 = m_ready2();
      f1 = bus.issue_valid1 && r1 && bus.Rd_wen1 && bus.Rd_addr1 != 0;
      f2 = bus.issue_valid2 && r2 && bus.Rd_wen2 && bus.Rd_addr2 != 0;
      st = (bus.issue_valid1 && !r1) || (bus.issue_valid2 && !r2 && !(bus.issue_valid1 && !r1));
      @(posedge clk);
      for (int r = 1; r < NREG; r++) begin
         n = mcnt[r]
           + int'(f1 && int'(bus.Rd_addr1) == r) + int'(f2 && int'(bus.Rd_addr2) == r)
           - int'(bus.Wen1 && int'(bus.Rd_addr1_wb) == r) - int'(bus.Wen2 && int'(bus.Rd_addr2_wb) == r);
         if (n < 0) begin
            n = 0;
            merr = 1'b1;
         end
         mcnt[r] = n;
      end
`ifdef SB_STALL_CNT_EN
      if (st) mstall = mstall + 1;
`else
      if (st) mstall = mstall + 0;
`endif
      #1;
   endtask

   task automatic drain();
      int a;
      clear_inputs();
      for (int k = 0; k < 128; k++) begin
         a = 0;
         for (int r = NREG - 1; r > 0; r--) if (mcnt[r] > 0) a = r;
         if (a == 0) break;
         set_wb(1, a, 0, 0);
         cycle();
      end
      clear_inputs();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      clear_inputs();
      set_slot1(1, 0, 0, 5, 1);
      cycle();
      cycle();
      clear_inputs();
      #2;
      n_checks++;
      if (bus.busy_vec !== m_busy_vec()) begin
         n_fail++; $display("FAIL reset_pre_busy: got %h expected %h", bus.busy_vec, m_busy_vec());
      end
      @(negedge clk);
      clk_en = 1'b0;
      #2;
      rst = 1'b1;
      #3;
      model_reset();
      n_checks++;
      if (bus.busy_vec !== '0) begin
         n_fail++; $display("FAIL reset_busy: got %h expected 0", bus.busy_vec);
      end
      n_checks++;
      if (bus.sb_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_err: got %b expected 0", bus.sb_err);
      end
      n_checks++;
      if (bus.issue_ready1 !== 1'b1 || bus.issue_ready2 !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b%b expected 11", bus.issue_ready1, bus.issue_ready2);
      end
      n_checks++;
      if (bus.stall_cycles !== 32'd0) begin
         n_fail++; $display("FAIL reset_stall: got %0d expected 0", bus.stall_cycles);
      end
      #3;
      rst = 1'b0;
      #2;
      clk_en = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_stall();
      int exp_stall;
      clear_inputs();
      set_slot1(1, 0, 0, 11, 1);
      cycle();
      set_slot1(1, 11, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         #2;
         n_checks++;
         if (bus.issue_ready1 !== 1'b0) begin
            n_fail++; $display("FAIL stall_blocked_%0d: got %b expected 0", i, bus.issue_ready1);
         end
         cycle();
      end
      clear_inputs();
      #2;
`ifdef SB_STALL_CNT_EN
      exp_stall = 5;
`else
      exp_stall = 0;
`endif
      n_checks++;
      if (bus.stall_cycles !== 32'(exp_stall)) begin
         n_fail++; $display("FAIL stall_count: got %0d expected %0d", bus.stall_cycles, exp_stall);
      end
      drain();
   endtask

   task automatic test_raw();
      clear_inputs();
      set_slot1(1, 0, 0, 9, 1);
      #2;
      n_checks++;
      if (bus.issue_ready1 !== 1'b1) begin
         n_fail++; $display("FAIL raw_c0_ready: got %b expected 1", bus.issue_ready1);
      end
      cycle();
      set_slot1(1, 9, 0, 0, 0);
      #2;
      n_checks++;
      if (bus.busy_vec[9] !== 1'b1 || bus.issue_ready1 !== 1'b0) begin
         n_fail++; $display("FAIL raw_c1: got busy9=%b ready1=%b expected busy9=1 ready1=0",
                            bus.busy_vec[9], bus.issue_ready1);
      end
      cycle();
      cycle();
      set_wb(1, 9, 0, 0);
      #2;
      n_checks++;
      if (bus.issue_ready1 !== 1'b0) begin
         n_fail++; $display("FAIL raw_c3_no_bypass: got %b expected 0", bus.issue_ready1);
      end
      cycle();
      set_wb(0, 0, 0, 0);
      #2;
      n_checks++;
      if (bus.issue_ready1 !== 1'b1 || bus.busy_vec[9] !== 1'b0) begin
         n_fail++; $display("FAIL raw_c4: got ready1=%b busy9=%b expected ready1=1 busy9=0",
                            bus.issue_ready1, bus.busy_vec[9]);
      end
      cycle();
      clear_inputs();
   endtask

   task automatic test_intra_pair();
      clear_inputs();
      set_slot1(1, 0, 0, 6, 1);
      set_slot2(1, 0, 6, 0, 0);
      #2;
      n_checks++;
      if (bus.issue_ready1 !== 1'b1 || bus.issue_ready2 !== 1'b0) begin
         n_fail++; $display("FAIL intra_ready: got %b%b expected 10", bus.issue_ready1, bus.issue_ready2);
      end
      cycle();
      clear_inputs();
      #2;
      n_checks++;
      if (bus.busy_vec[6] !== 1'b1) begin
         n_fail++; $display("FAIL intra_busy6: got %b expected 1", bus.busy_vec[6]);
      end
      drain();
   endtask

   task automatic test_saturation();
      clear_inputs();
      set_slot1(1, 0, 0, 7, 1);
      for (int i = 0; i < 3; i++) begin
         #2;
         n_checks++;
         if (bus.issue_ready1 !== 1'b1) begin
            n_fail++; $display("FAIL sat_issue_%0d: got %b expected 1", i, bus.issue_ready1);
         end
         cycle();
      end
      #2;
      n_checks++;
      if (bus.issue_ready1 !== 1'b0) begin
         n_fail++; $display("FAIL sat_full: got %b expected 0", bus.issue_ready1);
      end
      cycle();
      clear_inputs();
      set_wb(1, 7, 1, 7);
      cycle();
      clear_inputs();
      set_slot1(1, 0, 0, 7, 1);
      #2;
      n_checks++;
      if (bus.issue_ready1 !== 1'b1 || bus.busy_vec[7] !== 1'b1) begin
         n_fail++; $display("FAIL sat_dual_wb: got ready1=%b busy7=%b expected 1 1",
                            bus.issue_ready1, bus.busy_vec[7]);
      end
      cycle();
      set_slot2(1, 0, 0, 7, 1);
      #2;
      n_checks++;
      if (bus.issue_ready1 !== 1'b1 || bus.issue_ready2 !== 1'b0) begin
         n_fail++; $display("FAIL sat_pair_capacity: got %b%b expected 10", bus.issue_ready1, bus.issue_ready2);
      end
      cycle();
      drain();
   endtask

   task automatic test_x0_underflow();
      clear_inputs();
      set_slot1(1, 0, 0, 0, 1);
      set_slot2(1, 0, 0, 0, 1);
      cycle();
      clear_inputs();
      #2;
      n_checks++;
      if (bus.busy_vec !== '0 || bus.sb_err !== 1'b0) begin
         n_fail++; $display("FAIL x0_ignored: got busy=%h err=%b expected 0 0", bus.busy_vec, bus.sb_err);
      end
      set_wb(0, 0, 1, 20);
      cycle();
      clear_inputs();
      #2;
      n_checks++;
      if (bus.busy_vec[20] !== 1'b0 || bus.sb_err !== 1'b1) begin
         n_fail++; $display("FAIL underflow: got busy20=%b err=%b expected 0 1", bus.busy_vec[20], bus.sb_err);
      end
      cycle();
      cycle();
      #2;
      n_checks++;
      if (bus.sb_err !== 1'b1) begin
         n_fail++; $display("FAIL err_sticky: got %b expected 1", bus.sb_err);
      end
   endtask

   task automatic test_random();
      bit e1, e2;
      for (int i = 0; i < 400; i++) begin
         set_slot1($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 3) != 0);
         set_slot2($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 3) != 0);
         set_wb($urandom_range(0, 2) == 0, $urandom_range(0, 7),
                $urandom_range(0, 2) == 0, $urandom_range(0, 7));
         #2;
         e1 = m_ready1();
         e2 = m_ready2();
         n_checks++;
         if (bus.issue_ready1 !== e1 || bus.issue_ready2 !== e2) begin
            n_fail++; $display("FAIL rand_ready[%0d]: got %b%b expected %b%b",
                               i, bus.issue_ready1, bus.issue_ready2, e1, e2);
         end
         n_checks++;
         if (bus.busy_vec !== m_busy_vec() || bus.sb_err !== merr) begin
            n_fail++; $display("FAIL rand_state[%0d]: got busy=%h err=%b expected busy=%h err=%b",
                               i, bus.busy_vec, bus.sb_err, m_busy_vec(), merr);
         end
         n_checks++;
         if (bus.stall_cycles !== 32'(mstall)) begin
            n_fail++; $display("FAIL rand_stall[%0d]: got %0d expected %0d", i, bus.stall_cycles, mstall);
         end
         cycle();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      model_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_stall();
      test_raw();
      test_intra_pair();
      test_saturation();
      test_x0_underflow();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
